secuenciador_instrucciones: RTL

// Issuing end of the ChocoRol instruction interface: holds a small loadable program of 20-bit

---
 rtl/secuenciador_instrucciones.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/secuenciador_instrucciones.sv
// Instruction sequencer for the ChocoRol datapath.
// Issues a loaded program word by word and buffers each result R in a small FIFO.
module secuenciador_instrucciones #(
    parameter int IW = 20,
    parameter int AW = 4,
    parameter int RD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    input  logic [AW-1:0] last_addr,
    output logic [IW-1:0] Instruccion,
    output logic          instr_valid,
    input  logic [IW-1:0] R,
    output logic [IW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy,
    output logic          done
);

    // RD must be a power of two >= 2 so the pointers wrap naturally
    localparam int DW = $clog2(RD);
    localparam int CW = DW + 1;
    localparam int MD = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] lastReg;

    logic [IW-1:0] progMem [MD];
    logic [IW-1:0] fifoMem [RD];
    logic [DW-1:0] wrPtr;
    logic [DW-1:0] rdPtr;
    logic [CW-1:0] count;

    logic          memWrite;
    logic          pushOk;
    logic          popOk;
    logic [IW-1:0] firstWord;
    logic [IW-1:0] nextWord;
    logic [AW-1:0] pcNext;

    // Loads only land while idle; a load in the start cycle must reach the first issue
    assign memWrite  = load_en && (state == IDLE);
    assign pcNext    = pc + 1'b1;
    assign firstWord = (memWrite && (load_addr == '0)) ? load_data : progMem[0];
    assign nextWord  = progMem[pcNext];

    // Push only on free space seen at this edge; a same-cycle pop does not count
    assign pushOk = (state == CAPTURE) && (count < CW'(RD));
    assign popOk  = res_valid && res_ready;

    assign res_valid = (count != '0);
    assign res_data  = res_valid ? fifoMem[rdPtr] : '0;

    // Program storage, deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (memWrite && !rst) begin
            progMem[load_addr] <= load_data;
        end
    end

    // Sequencing FSM with registered interface outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            lastReg     <= '0;
            Instruccion <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            done        <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ISSUE;
                        pc          <= '0;
                        lastReg     <= last_addr;
                        Instruccion <= firstWord;
                        instr_valid <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (pushOk) begin
                        if (pc == lastReg) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            pc          <= pcNext;
                            Instruccion <= nextWord;
                            instr_valid <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    pc    <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Result storage; stale entries are unreachable once the count drops
    always_ff @(posedge clk) begin
        if (pushOk && !rst) begin
            fifoMem[wrPtr] <= R;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popOk) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({pushOk, popOk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
